// File: rtl/clk_meas_pkg.sv
// Shared definitions for the slow-clock measurement blocks: state encoding
// and default counter width / timeout, so dividers and meters agree.
package clk_meas_pkg;

    localparam int CNT_W_DEF          = 33;
    localparam int TIMEOUT_CYCLES_DEF = 200000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2,
        S_LOST = 2'd3
    } meas_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, followed by a history
// flop that yields single-cycle rise/fall strobes in the local clock domain.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    // Remember the previous synchronised level for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~hist_q;
    assign fall_o = ~sync_o & hist_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period (and optionally high time) of a slow asynchronous
// square wave in clk_in cycles, with loss-of-signal timeout.
// Optional feature macro: DUTY_MEAS_EN builds the high-time counter; when
// undefined high_out is tied to zero.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

    meas_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic sync_s;
    logic rise_s;
    logic fall_unused;
    logic arm_expired;
    logic meas_expired;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_in),
        .rst_ni (rst),
        .async_i(sig_in),
        .sync_o (sync_s),
        .rise_o (rise_s),
        .fall_o (fall_unused)
    );

    // In ARM the counter counts waiting cycles from 0, so the last allowed
    // cycle is TIMEOUT-1; in MEASURE it starts at 1, so the limit is TIMEOUT.
    // A rise in the limit cycle always takes priority over the timeout.
    assign arm_expired  = (state_q == S_ARM)  && !rise_s && (cnt_q == TO_M1);
    assign meas_expired = (state_q == S_MEAS) && !rise_s && (cnt_q == TO_V);

    // State register
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; dropping enable overrides every other event
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARM;
                S_ARM: begin
                    if (rise_s)           state_d = S_MEAS;
                    else if (arm_expired) state_d = S_LOST;
                end
                S_MEAS: if (meas_expired) state_d = S_LOST;
                S_LOST: if (rise_s)       state_d = S_MEAS;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Counter, result and status updates for the current state
    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (!enable) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
                S_ARM: begin
                    if (rise_s) begin
                        cnt_d = ONE;
                    end else if (arm_expired) begin
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                S_MEAS: begin
                    if (rise_s) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = ONE;
                    end else if (meas_expired) begin
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                S_LOST: begin
                    if (rise_s) begin
                        cnt_d     = ONE;
                        timeout_d = 1'b0;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_out = period_q;
    assign meas_valid = valid_q;
    assign timeout    = timeout_q;

`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;

    // High-time counter follows the period counter; the rise cycle itself
    // is high, hence the restart value of 1
    always_comb begin
        hcnt_d = hcnt_q;
        high_d = high_q;
        if (!enable) begin
            hcnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: hcnt_d = '0;
                S_ARM, S_LOST: hcnt_d = rise_s ? ONE : '0;
                S_MEAS: begin
                    if (rise_s) begin
                        high_d = hcnt_q;
                        hcnt_d = ONE;
                    end else if (meas_expired) begin
                        hcnt_d = '0;
                    end else begin
                        hcnt_d = hcnt_q + CNT_W'(sync_s);
                    end
                end
                default: hcnt_d = '0;
            endcase
        end
    end

    // High-time registers
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign high_out = high_q;
`else
    logic sync_unused;
    assign sync_unused = sync_s;
    assign high_out    = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter (TIMEOUT_CYCLES=50, SYNC_STAGES=2).
module tb_clk_period_meter;
    import clk_meas_pkg::*;

    localparam int W  = 33;
    localparam int TO = 50;

    logic         clk_in = 1'b0;
    logic         rst    = 1'b0;
    logic         enable = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] period_out;
    logic [W-1:0] high_out;
    logic         meas_valid;
    logic         timeout;

    clk_period_meter #(
        .CNT_W(W),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .enable    (enable),
        .sig_in    (sig_in),
        .period_out(period_out),
        .high_out  (high_out),
        .meas_valid(meas_valid),
        .timeout   (timeout)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int           cyc;
        logic [W-1:0] per;
        logic [W-1:0] hi;
    } rec_t;

    typedef struct {
        int hi_len;
        int lo_len;
        int exp_per;
        int exp_hi;
    } vec_t;

    int   cyc = 0;
    rec_t vq[$];
    int   tq[$];
    logic to_prev = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Record every valid pulse and every rising edge of timeout
    always @(negedge clk_in) begin
        if (meas_valid) vq.push_back('{cyc, period_out, high_out});
        if (timeout && !to_prev) tq.push_back(cyc);
        to_prev = timeout;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int p = 0; p < n; p++) begin
            sig_in = 1'b1;
            step(h);
            sig_in = 1'b0;
            step(l);
        end
    endtask

    function automatic int exp_high(input int h);
`ifdef DUTY_MEAS_EN
        return h;
`else
        return 0;
`endif
    endfunction

    vec_t vt[5];
    int   vb, tb0, last_cyc, w;

    initial begin
        vt[0] = '{5, 5, 10, 5};
        vt[1] = '{3, 9, 12, 3};
        vt[2] = '{1, 6, 7, 1};
        vt[3] = '{8, 2, 10, 8};
        vt[4] = '{6, 14, 20, 6};

        // Reset state
        #2;
        check("rst_period", 64'(period_out), 0);
        check("rst_high", 64'(high_out), 0);
        check("rst_valid", 64'(meas_valid), 0);
        check("rst_timeout", 64'(timeout), 0);
        step(2);
        rst = 1'b1;
        step(2);

        // Table of periodic patterns: 4 rises give 3 reports
        for (int i = 0; i < 5; i++) begin
            enable = 1'b0;
            step(3);
            vb = vq.size();
            enable = 1'b1;
            step(3);
            wave(vt[i].hi_len, vt[i].lo_len, 4);
            step(4);
            check($sformatf("v%0d_count", i), vq.size() - vb, 3);
            if (vq.size() - vb == 3) begin
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("v%0d_per%0d", i, k), 64'(vq[vb+k].per), vt[i].exp_per);
                    check($sformatf("v%0d_hi%0d", i, k), 64'(vq[vb+k].hi), exp_high(vt[i].exp_hi));
                end
                for (int k = 1; k < 3; k++)
                    check($sformatf("v%0d_gap%0d", i, k), vq[vb+k].cyc - vq[vb+k-1].cyc, vt[i].exp_per);
            end
            check($sformatf("v%0d_timeout", i), 64'(timeout), 0);
        end

        // ARM timeout boundary: timeout after exactly TO cycles in ARM
        enable = 1'b0;
        step(3);
        enable = 1'b1;
        step(TO);
        check("arm_to_before", 64'(timeout), 0);
        step(1);
        check("arm_to_after", 64'(timeout), 1);
        enable = 1'b0;
        step(1);
        check("arm_to_disable", 64'(timeout), 0);

        // Loss of signal in MEASURE and recovery
        step(2);
        enable = 1'b1;
        step(3);
        vb  = vq.size();
        tb0 = tq.size();
        wave(5, 5, 2);
        w = 0;
        while (!timeout && w < 200) begin
            step(1);
            w++;
        end
        check("lost_seen", 64'(timeout), 1);
        check("lost_count", vq.size() - vb, 1);
        if (vq.size() - vb == 1 && tq.size() - tb0 == 1)
            check("lost_delay", tq[tb0] - vq[vb].cyc, TO);
        check("lost_period_kept", 64'(period_out), 10);
        sig_in = 1'b1;
        step(4);
        check("recover_clear", 64'(timeout), 0);
        check("recover_no_valid", vq.size() - vb, 1);
        sig_in = 1'b0;
        step(10);
        sig_in = 1'b1;
        step(5);
        check("recover_count", vq.size() - vb, 2);
        if (vq.size() - vb == 2)
            check("recover_period", 64'(vq[vb+1].per), 14);
        sig_in = 1'b0;
        step(3);

        // enable dropping in the same cycle as a rise
        enable = 1'b0;
        step(3);
        enable = 1'b1;
        step(3);
        wave(5, 5, 2);
        vb = vq.size();
        sig_in = 1'b1;
        step(2);
        enable = 1'b0;
        step(5);
        check("dis_no_valid", vq.size() - vb, 0);
        check("dis_timeout", 64'(timeout), 0);
        check("dis_period_kept", 64'(period_out), 10);
        sig_in = 1'b0;
        step(3);
        enable = 1'b1;
        step(3);
        wave(5, 5, 2);
        step(4);
        check("reen_count", vq.size() - vb, 1);
        if (vq.size() - vb == 1)
            check("reen_period", 64'(vq[vb].per), 10);

        // Rise exactly at the timeout limit wins
        enable = 1'b0;
        step(3);
        enable = 1'b1;
        step(3);
        vb  = vq.size();
        tb0 = tq.size();
        wave(5, TO - 5, 2);
        enable = 1'b0;
        step(2);
        check("edge_count", vq.size() - vb, 1);
        if (vq.size() - vb == 1)
            check("edge_period", 64'(vq[vb].per), TO);
        check("edge_no_timeout", tq.size() - tb0, 0);

        // Asynchronous reset mid-measurement
        enable = 1'b1;
        step(3);
        wave(4, 4, 2);
        check("pre_rst_period", 64'(period_out), 8);
        vb = vq.size();
        sig_in = 1'b1;
        step(3);
        #2;
        rst = 1'b0;
        #1;
        check("arst_period", 64'(period_out), 0);
        check("arst_high", 64'(high_out), 0);
        check("arst_valid", 64'(meas_valid), 0);
        check("arst_timeout", 64'(timeout), 0);
        sig_in = 1'b0;
        @(posedge clk_in);
        #4;
        rst = 1'b1;
        #1;
        check("arst_state_idle", 64'(dut.state_q), 64'(S_IDLE));
        step(1);
        step(2);
        check("arst_no_valid", vq.size() - vb, 0);
        wave(5, 5, 3);
        step(4);
        check("post_rst_count", vq.size() - vb, 2);
        last_cyc = 0;
        for (int k = 0; k < vq.size() - vb && k < 2; k++)
            check($sformatf("post_rst_per%0d", k), 64'(vq[vb+k].per), 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
Measures the period of a slow, square-wave clock-like signal, such as the output of our clock dividers, in cycles of the fast system clock. The signal is treated as asynchronous: it is synchronised, its rising edges are detected, and the block reports the cycle count between consecutive rising edges with a one-cycle valid strobe. It sits on the receive side of any divided or externally sourced slow clock and is used for self-check and for reporting frequency to status registers.

Parameters:
CNT_W, 33, width of the period and high-time counters and outputs.
TIMEOUT_CYCLES, 200000, number of clk_in cycles without a rising edge before a loss-of-signal timeout; must be less than 2^CNT_W.
SYNC_STAGES, 2, flip-flop stages in the input synchroniser; minimum 2.

Ports:
clk_in, input, 1, system clock; all logic is on its rising edge.
rst, input, 1, asynchronous active-low reset; the block is in reset while rst=0.
enable, input, 1, measurement enable; 0 forces IDLE.
sig_in, input, 1, asynchronous signal under measurement.
period_out, output, CNT_W, clk_in cycles between the last two detected rising edges of sig_in.
high_out, output, CNT_W, clk_in cycles sig_in was high within that period; only meaningful with DUTY_MEAS_EN.
meas_valid, output, 1, one-cycle pulse when period_out and high_out update.
timeout, output, 1, level; set on loss of signal, cleared by the next rising edge or by leaving the measuring states.

Behaviour:
- Reset (rst=0, asynchronous): synchroniser flops, edge-history flop and counters are cleared. State is IDLE, period_out=0, high_out=0, meas_valid=0, timeout=0.
- Synchroniser: SYNC_STAGES flops followed by one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Latency from a sig_in rising edge to rise is SYNC_STAGES to SYNC_STAGES+1 cycles.
- States: IDLE, ARM, MEASURE, LOST.
- IDLE: counters are held at 0. If enable=1, go to ARM next cycle.
- ARM (waits for the first edge; nothing is reported):
  - On rise: cnt<=1, hcnt<=1, go to MEASURE.
  - If TIMEOUT_CYCLES cycles pass with no rise: timeout<=1, go to LOST.
- MEASURE: cnt increments by 1 every cycle; hcnt increments every cycle where sync=1.
  - On rise: period_out<=cnt, high_out<=hcnt, meas_valid<=1 for exactly one cycle, then cnt<=1, hcnt<=1.
  - Effect: period_out equals the exact distance in clk_in cycles between the two rise cycles.
  - If cnt reaches TIMEOUT_CYCLES with no rise: timeout<=1, go to LOST. period_out and high_out keep their last values, and no meas_valid is issued.
- LOST:
  - On rise: timeout<=0, cnt<=1, hcnt<=1, go to MEASURE. The first period after recovery is reported on the following rise.
- enable=0 in any state: go to IDLE next cycle, timeout<=0, counters cleared. period_out and high_out keep their values.
- Simultaneous events:
  - rise in the same cycle cnt reaches TIMEOUT_CYCLES: the rise wins and a valid measurement is reported.
  - enable falling in the same cycle as rise: enable wins and there is no meas_valid.
- Counters never wrap, because the timeout bounds cnt to TIMEOUT_CYCLES.
- Glitches shorter than one clk_in period may be missed; this is by design.
- Reset during MEASURE aborts the measurement with no meas_valid.

Optional Feature:
DUTY_MEAS_EN
- Defined: the hcnt counter and high_out register are built, and high_out behaves as described above.
- Undefined: hcnt logic is not instantiated and high_out is tied to 0. Period measurement and timeout are unchanged.

Decomposition:
- Shared package clk_meas_pkg holds:
  - the state encoding constants S_IDLE=2'd0, S_ARM=2'd1, S_MEAS=2'd2, S_LOST=2'd3;
  - the default CNT_W and TIMEOUT_CYCLES constants, so divider and meter instances agree.
- One natural sub-module: sync_edge_det, which contains the SYNC_STAGES-deep synchroniser plus rise/fall detection. It is reusable by other asynchronous-input blocks.

Test Plan:
1. Drive sig_in from a clk_divider with toggle_value=4 (period 10 cycles), enable=1 → first meas_valid on the 2nd detected rise, period_out=10, high_out=5, then a meas_valid pulse every 10 cycles.
2. sig_in high 3 cycles, low 9 cycles, repeating → period_out=12, high_out=3 with DUTY_MEAS_EN; high_out=0 without it.
3. TIMEOUT_CYCLES=50; stop sig_in after a valid measurement of 10 → timeout rises 50 cycles after the last rise and period_out stays 10. Restarting sig_in clears timeout on the first rise, and the next rise gives meas_valid with the new period.
4. Deassert enable mid-period → IDLE next cycle, no meas_valid and timeout=0. Re-enable → ARM, and the first report comes after two rises.
5. Pull rst low asynchronously mid-MEASURE, between clock edges → all outputs 0 immediately. After release, the state is IDLE and operation resumes correctly.
6. Force rise in the same cycle cnt==TIMEOUT_CYCLES → meas_valid=1, period_out=TIMEOUT_CYCLES, timeout stays 0.
